// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi
//   Parametrised vending-machine control core running on the debounced event
//   clock. Tracks credit, per-item stock and sticky reminder flags, and pays
//   back credit coin by coin through a valid/ready coin-return handshake.
//
// Ports
//   clk, rst_n       event clock, asynchronous active-low reset
//   coin_n           coin buttons, active-low (index 0 = smallest value)
//   buy_n            purchase buttons, active-low
//   refund_n         refund button, active-low
//   restock          active-high per-item refill to full scale
//   chg_ready        coin-return mechanism accepts the presented coin
//   credit           current credit in units of 0.1
//   stock            packed per-item stock counts (item 0 = LSBs)
//   vend_valid       one-cycle pulse, item vend_item released
//   vend_item        index of the vended item
//   chg_valid        return-coin request, chg_coin holds the denomination
//   coin_reject      one-cycle pulse, inserted coin returned unaccepted
//   remind_funds     sticky, insufficient credit for item i
//   remind_soldout   sticky, item i empty
//   remind_refund    sticky, refund completed (or nothing to refund)
//   busy             change is being paid out
module vend_ctrl_multi #(
  parameter int N_COINS    = 3,
  parameter int N_ITEMS    = 2,
  parameter int CW         = 10,
  parameter int MAX_CREDIT = 999,
  parameter logic [N_COINS*CW-1:0] COIN_VALUES = {10'd50, 10'd10, 10'd5},
  parameter logic [N_ITEMS*CW-1:0] PRICES      = {10'd25, 10'd15},
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 9
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [N_COINS-1:0]                               coin_n,
  input  logic [N_ITEMS-1:0]                               buy_n,
  input  logic                                             refund_n,
  input  logic [N_ITEMS-1:0]                               restock,
  input  logic                                             chg_ready,
  output logic [CW-1:0]                                    credit,
  output logic [N_ITEMS*STOCK_W-1:0]                       stock,
  output logic                                             vend_valid,
  output logic [((N_ITEMS > 1) ? $clog2(N_ITEMS) : 1)-1:0] vend_item,
  output logic                                             chg_valid,
  output logic [((N_COINS > 1) ? $clog2(N_COINS) : 1)-1:0] chg_coin,
  output logic                                             coin_reject,
  output logic [N_ITEMS-1:0]                               remind_funds,
  output logic [N_ITEMS-1:0]                               remind_soldout,
  output logic                                             remind_refund,
  output logic                                             busy
);

  localparam int IW  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int CSW = (N_COINS > 1) ? $clog2(N_COINS) : 1;
  localparam logic [CW:0] MAX_EXT = (CW+1)'(MAX_CREDIT);

  typedef enum logic {
    S_IDLE,
    S_CHANGE
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [N_ITEMS];
  logic [STOCK_W-1:0]  stock_d [N_ITEMS];
  logic [N_COINS-1:0]  coin_prev_q;
  logic [N_ITEMS-1:0]  buy_prev_q;
  logic                refund_prev_q;
  logic                vend_valid_q, vend_valid_d;
  logic [IW-1:0]       vend_item_q, vend_item_d;
  logic                chg_valid_q, chg_valid_d;
  logic [CSW-1:0]      chg_coin_q, chg_coin_d;
  logic                coin_reject_q, coin_reject_d;
  logic [N_ITEMS-1:0]  funds_q, funds_d;
  logic [N_ITEMS-1:0]  soldout_q, soldout_d;
  logic                rflag_q, rflag_d;

  logic [N_COINS-1:0]  coin_ev;
  logic [N_ITEMS-1:0]  buy_ev;
  logic                refund_ev;
  logic [N_COINS-1:0]  coin_gnt;
  logic [N_ITEMS-1:0]  buy_gnt;
  logic [CW-1:0]       coin_add;
  logic [CW:0]         sum_w;
  logic [CW-1:0]       chg_sub;

  // Largest denomination not exceeding c. Credit is always a multiple of
  // the smallest coin, so a nonzero credit always finds a coin.
  function automatic logic [CSW-1:0] select_coin(input logic [CW-1:0] c);
    logic [CSW-1:0] sel;
    sel = '0;
    for (int unsigned k = 0; k < N_COINS; k++) begin
      if (COIN_VALUES[k*CW +: CW] <= c) sel = CSW'(k);
    end
    return sel;
  endfunction

  // Press = released last cycle, pressed now.
  assign coin_ev   = coin_prev_q & ~coin_n;
  assign buy_ev    = buy_prev_q & ~buy_n;
  assign refund_ev = refund_prev_q & ~refund_n;

  // Highest coin index wins; lowest buy index wins (isolate lowest set bit).
  always_comb begin
    coin_gnt = '0;
    coin_add = '0;
    for (int unsigned k = 0; k < N_COINS; k++) begin
      if (coin_ev[k]) begin
        coin_gnt = '0;
        coin_gnt[k] = 1'b1;
        coin_add = COIN_VALUES[k*CW +: CW];
      end
    end
  end

  assign buy_gnt = buy_ev & (~buy_ev + 1'b1);
  assign sum_w   = {1'b0, credit_q} + {1'b0, coin_add};

  always_comb begin
    chg_sub = '0;
    for (int unsigned k = 0; k < N_COINS; k++) begin
      if (chg_coin_q == CSW'(k)) chg_sub = COIN_VALUES[k*CW +: CW];
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    stock_d       = stock_q;
    vend_valid_d  = 1'b0;
    vend_item_d   = vend_item_q;
    chg_valid_d   = chg_valid_q;
    chg_coin_d    = chg_coin_q;
    coin_reject_d = 1'b0;
    funds_d       = funds_q;
    soldout_d     = soldout_q;
    rflag_d       = rflag_q;

    case (state_q)
      S_IDLE: begin
        if (refund_ev) begin
          if (credit_q == '0) begin
            rflag_d = 1'b1;
          end else begin
            state_d     = S_CHANGE;
            chg_valid_d = 1'b1;
            chg_coin_d  = select_coin(credit_q);
          end
        end else if (|coin_ev) begin
          if (sum_w > MAX_EXT) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = sum_w[CW-1:0];
            rflag_d  = 1'b0;
            for (int unsigned i = 0; i < N_ITEMS; i++) begin
              if (credit_d >= PRICES[i*CW +: CW]) funds_d[i] = 1'b0;
            end
          end
        end else if (|buy_ev) begin
          for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (buy_gnt[i]) begin
              if (stock_q[i] == '0) begin
                soldout_d[i] = 1'b1;
              end else if (credit_q < PRICES[i*CW +: CW]) begin
                funds_d[i] = 1'b1;
              end else begin
                credit_d     = credit_q - PRICES[i*CW +: CW];
                stock_d[i]   = stock_q[i] - 1'b1;
                funds_d[i]   = 1'b0;
                vend_valid_d = 1'b1;
                vend_item_d  = IW'(i);
              end
            end
          end
        end
      end

      S_CHANGE: begin
        if (|coin_ev) coin_reject_d = 1'b1;
        if (chg_valid_q && chg_ready) begin
          credit_d = credit_q - chg_sub;
          if (credit_d == '0) begin
            chg_valid_d = 1'b0;
            rflag_d     = 1'b1;
            state_d     = S_IDLE;
          end else begin
            chg_coin_d = select_coin(credit_d);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Applied last so a same-cycle vend still leaves the item full.
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (restock[i]) begin
        stock_d[i]   = '1;
        soldout_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      for (int unsigned i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      coin_prev_q   <= '1;
      buy_prev_q    <= '1;
      refund_prev_q <= 1'b1;
      vend_valid_q  <= 1'b0;
      vend_item_q   <= '0;
      chg_valid_q   <= 1'b0;
      chg_coin_q    <= '0;
      coin_reject_q <= 1'b0;
      funds_q       <= '0;
      soldout_q     <= '0;
      rflag_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      stock_q       <= stock_d;
      coin_prev_q   <= coin_n;
      buy_prev_q    <= buy_n;
      refund_prev_q <= refund_n;
      vend_valid_q  <= vend_valid_d;
      vend_item_q   <= vend_item_d;
      chg_valid_q   <= chg_valid_d;
      chg_coin_q    <= chg_coin_d;
      coin_reject_q <= coin_reject_d;
      funds_q       <= funds_d;
      soldout_q     <= soldout_d;
      rflag_q       <= rflag_d;
    end
  end

  always_comb begin
    stock = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) stock[i*STOCK_W +: STOCK_W] = stock_q[i];
  end

  assign credit         = credit_q;
  assign vend_valid     = vend_valid_q;
  assign vend_item      = vend_item_q;
  assign chg_valid      = chg_valid_q;
  assign chg_coin       = chg_coin_q;
  assign coin_reject    = coin_reject_q;
  assign remind_funds   = funds_q;
  assign remind_soldout = soldout_q;
  assign remind_refund  = rflag_q;
  assign busy           = (state_q == S_CHANGE);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
module tb_vend_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] coin_n;
  logic [1:0] buy_n;
  logic       refund_n;
  logic [1:0] restock;
  logic       chg_ready;
  logic [9:0] credit;
  logic [7:0] stock;
  logic       vend_valid;
  logic [0:0] vend_item;
  logic       chg_valid;
  logic [1:0] chg_coin;
  logic       coin_reject;
  logic [1:0] remind_funds;
  logic [1:0] remind_soldout;
  logic       remind_refund;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  vend_ctrl_multi #(
    .N_COINS(3), .N_ITEMS(2), .CW(10), .MAX_CREDIT(999),
    .COIN_VALUES({10'd50, 10'd10, 10'd5}), .PRICES({10'd25, 10'd15}),
    .STOCK_W(4), .STOCK_INIT(9)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin_n(coin_n), .buy_n(buy_n),
    .refund_n(refund_n), .restock(restock), .chg_ready(chg_ready),
    .credit(credit), .stock(stock), .vend_valid(vend_valid),
    .vend_item(vend_item), .chg_valid(chg_valid), .chg_coin(chg_coin),
    .coin_reject(coin_reject), .remind_funds(remind_funds),
    .remind_soldout(remind_soldout), .remind_refund(remind_refund),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; coin_n = '1; buy_n = '1; refund_n = 1'b1;
    restock = '0; chg_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Hold the given buttons pressed across one rising edge, return at the
  // following falling edge with the registered response visible.
  task automatic press(input logic [2:0] c, input logic [1:0] b,
                       input logic r, input logic [1:0] rs);
    @(negedge clk);
    coin_n = ~c; buy_n = ~b; refund_n = ~r; restock = rs;
    @(negedge clk);
    coin_n = '1; buy_n = '1; refund_n = 1'b1; restock = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (credit !== 10'd0) $display("FAIL reset_credit: got %0d want 0", credit); else n_pass++;
    n_checks++; if (stock !== 8'h99) $display("FAIL reset_stock: got %h want 99", stock); else n_pass++;
    n_checks++; if ({vend_valid, chg_valid, coin_reject, busy} !== 4'b0)
      $display("FAIL reset_pulses: got %b want 0000", {vend_valid, chg_valid, coin_reject, busy}); else n_pass++;
    n_checks++; if ({remind_funds, remind_soldout, remind_refund} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {remind_funds, remind_soldout, remind_refund}); else n_pass++;
    n_checks++; if ({chg_coin, vend_item} !== 3'b0)
      $display("FAIL reset_idx: got %b want 000", {chg_coin, vend_item}); else n_pass++;
  endtask

  task automatic test_vend();
    do_reset();
    press(3'b100, 2'b00, 1'b0, 2'b00);
    n_checks++; if (credit !== 10'd50) $display("FAIL vend_coin2: got %0d want 50", credit); else n_pass++;
    press(3'b000, 2'b01, 1'b0, 2'b00);
    n_checks++; if (vend_valid !== 1'b1 || vend_item !== 1'b0)
      $display("FAIL vend_pulse: got v=%b i=%0d want v=1 i=0", vend_valid, vend_item); else n_pass++;
    n_checks++; if (credit !== 10'd35) $display("FAIL vend_credit: got %0d want 35", credit); else n_pass++;
    n_checks++; if (stock[3:0] !== 4'd8) $display("FAIL vend_stock: got %0d want 8", stock[3:0]); else n_pass++;
    @(negedge clk);
    n_checks++; if (vend_valid !== 1'b0) $display("FAIL vend_onecycle: got %b want 0", vend_valid); else n_pass++;
  endtask

  task automatic test_funds();
    do_reset();
    press(3'b000, 2'b10, 1'b0, 2'b00);
    n_checks++; if (remind_funds !== 2'b10 || vend_valid !== 1'b0)
      $display("FAIL funds_set: got f=%b v=%b want f=10 v=0", remind_funds, vend_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      press(3'b010, 2'b00, 1'b0, 2'b00);
      n_checks++; if (credit !== 10'(10 * (i + 1)))
        $display("FAIL funds_credit%0d: got %0d want %0d", i, credit, 10 * (i + 1)); else n_pass++;
      n_checks++; if (remind_funds[1] !== ((i == 2) ? 1'b0 : 1'b1))
        $display("FAIL funds_flag%0d: got %b want %b", i, remind_funds[1], (i == 2) ? 1'b0 : 1'b1); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 19; i++) press(3'b100, 2'b00, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) press(3'b010, 2'b00, 1'b0, 2'b00);
    n_checks++; if (credit !== 10'd980) $display("FAIL ovf_build: got %0d want 980", credit); else n_pass++;
    press(3'b100, 2'b00, 1'b0, 2'b00);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 10'd980)
      $display("FAIL ovf_reject50: got r=%b c=%0d want r=1 c=980", coin_reject, credit); else n_pass++;
    @(negedge clk);
    n_checks++; if (coin_reject !== 1'b0) $display("FAIL ovf_onecycle: got %b want 0", coin_reject); else n_pass++;
    press(3'b001, 2'b00, 1'b0, 2'b00);
    n_checks++; if (coin_reject !== 1'b0 || credit !== 10'd985)
      $display("FAIL ovf_coin0: got r=%b c=%0d want r=0 c=985", coin_reject, credit); else n_pass++;
    press(3'b010, 2'b00, 1'b0, 2'b00);
    n_checks++; if (credit !== 10'd995) $display("FAIL ovf_coin1: got %0d want 995", credit); else n_pass++;
    press(3'b010, 2'b00, 1'b0, 2'b00);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 10'd995)
      $display("FAIL ovf_reject10: got r=%b c=%0d want r=1 c=995", coin_reject, credit); else n_pass++;
    press(3'b001, 2'b00, 1'b0, 2'b00);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 10'd995)
      $display("FAIL ovf_reject5: got r=%b c=%0d want r=1 c=995", coin_reject, credit); else n_pass++;
  endtask

  task automatic test_refund();
    logic [1:0] exp_coin [3];
    logic [9:0] exp_cred [3];
    exp_coin = '{2'd2, 2'd1, 2'd0};
    exp_cred = '{10'd65, 10'd15, 10'd5};
    do_reset();
    press(3'b100, 2'b00, 1'b0, 2'b00);
    press(3'b010, 2'b00, 1'b0, 2'b00);
    press(3'b001, 2'b00, 1'b0, 2'b00);
    chg_ready = 1'b1;
    press(3'b000, 2'b00, 1'b1, 2'b00);
    n_checks++; if (busy !== 1'b1) $display("FAIL refund_busy: got %b want 1", busy); else n_pass++;
    for (int s = 0; s < 3; s++) begin
      n_checks++; if (chg_valid !== 1'b1 || chg_coin !== exp_coin[s] || credit !== exp_cred[s])
        $display("FAIL refund_step%0d: got v=%b coin=%0d c=%0d want v=1 coin=%0d c=%0d",
                 s, chg_valid, chg_coin, credit, exp_coin[s], exp_cred[s]); else n_pass++;
      @(negedge clk);
    end
    n_checks++; if (chg_valid !== 1'b0 || busy !== 1'b0 || credit !== 10'd0 || remind_refund !== 1'b1)
      $display("FAIL refund_done: got v=%b b=%b c=%0d rr=%b want v=0 b=0 c=0 rr=1",
               chg_valid, busy, credit, remind_refund); else n_pass++;
    press(3'b000, 2'b00, 1'b1, 2'b00);
    n_checks++; if (busy !== 1'b0 || remind_refund !== 1'b1)
      $display("FAIL refund_zero: got b=%b rr=%b want b=0 rr=1", busy, remind_refund); else n_pass++;
  endtask

  task automatic test_stall();
    bit done;
    do_reset();
    press(3'b100, 2'b00, 1'b0, 2'b00);
    press(3'b010, 2'b00, 1'b0, 2'b00);
    press(3'b001, 2'b00, 1'b0, 2'b00);
    chg_ready = 1'b0;
    press(3'b000, 2'b00, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (chg_valid !== 1'b1 || chg_coin !== 2'd2 || credit !== 10'd65)
        $display("FAIL stall_hold%0d: got v=%b coin=%0d c=%0d want v=1 coin=2 c=65",
                 i, chg_valid, chg_coin, credit); else n_pass++;
      @(negedge clk);
    end
    press(3'b001, 2'b00, 1'b0, 2'b00);
    n_checks++; if (coin_reject !== 1'b1 || credit !== 10'd65 || chg_coin !== 2'd2)
      $display("FAIL stall_coin: got r=%b c=%0d coin=%0d want r=1 c=65 coin=2",
               coin_reject, credit, chg_coin); else n_pass++;
    press(3'b000, 2'b01, 1'b0, 2'b00);
    n_checks++; if (vend_valid !== 1'b0 || credit !== 10'd65)
      $display("FAIL stall_buy: got v=%b c=%0d want v=0 c=65", vend_valid, credit); else n_pass++;
    chg_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    n_checks++; if (!done || credit !== 10'd0 || remind_refund !== 1'b1)
      $display("FAIL stall_finish: got done=%b c=%0d rr=%b want done=1 c=0 rr=1",
               done, credit, remind_refund); else n_pass++;
  endtask

  task automatic test_soldout();
    do_reset();
    for (int i = 0; i < 3; i++) press(3'b100, 2'b00, 1'b0, 2'b00);
    for (int i = 0; i < 9; i++) begin
      press(3'b000, 2'b01, 1'b0, 2'b00);
      n_checks++; if (vend_valid !== 1'b1 || stock[3:0] !== 4'(8 - i))
        $display("FAIL sold_buy%0d: got v=%b s=%0d want v=1 s=%0d", i, vend_valid, stock[3:0], 8 - i); else n_pass++;
    end
    n_checks++; if (credit !== 10'd15) $display("FAIL sold_credit: got %0d want 15", credit); else n_pass++;
    press(3'b000, 2'b01, 1'b0, 2'b00);
    n_checks++; if (vend_valid !== 1'b0 || remind_soldout !== 2'b01 || stock[3:0] !== 4'd0 || credit !== 10'd15)
      $display("FAIL sold_tenth: got v=%b so=%b s=%0d c=%0d want v=0 so=01 s=0 c=15",
               vend_valid, remind_soldout, stock[3:0], credit); else n_pass++;
    press(3'b000, 2'b00, 1'b0, 2'b01);
    n_checks++; if (stock[3:0] !== 4'd15 || remind_soldout !== 2'b00 || stock[7:4] !== 4'd9)
      $display("FAIL sold_restock: got s=%h so=%b want s=9f so=00", stock, remind_soldout); else n_pass++;
    press(3'b000, 2'b01, 1'b0, 2'b00);
    n_checks++; if (vend_valid !== 1'b1 || credit !== 10'd0 || stock[3:0] !== 4'd14)
      $display("FAIL sold_exact: got v=%b c=%0d s=%0d want v=1 c=0 s=14", vend_valid, credit, stock[3:0]); else n_pass++;
  endtask

  task automatic test_restock_vend();
    press(3'b010, 2'b00, 1'b0, 2'b00);
    press(3'b001, 2'b00, 1'b0, 2'b00);
    press(3'b000, 2'b01, 1'b0, 2'b01);
    n_checks++; if (vend_valid !== 1'b1 || stock[3:0] !== 4'd15 || credit !== 10'd0)
      $display("FAIL restock_vend: got v=%b s=%0d c=%0d want v=1 s=15 c=0", vend_valid, stock[3:0], credit); else n_pass++;
  endtask

  task automatic test_simul();
    do_reset();
    press(3'b100, 2'b00, 1'b0, 2'b00);
    press(3'b010, 2'b01, 1'b0, 2'b00);
    n_checks++; if (credit !== 10'd60 || vend_valid !== 1'b0 || stock[3:0] !== 4'd9)
      $display("FAIL simul_coin_buy: got c=%0d v=%b s=%0d want c=60 v=0 s=9",
               credit, vend_valid, stock[3:0]); else n_pass++;
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    press(3'b100, 2'b00, 1'b0, 2'b00);
    press(3'b010, 2'b00, 1'b0, 2'b00);
    chg_ready = 1'b0;
    press(3'b000, 2'b00, 1'b1, 2'b00);
    n_checks++; if (chg_valid !== 1'b1 || credit !== 10'd60)
      $display("FAIL midrst_pre: got v=%b c=%0d want v=1 c=60", chg_valid, credit); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (chg_valid !== 1'b0 || credit !== 10'd0 || busy !== 1'b0)
      $display("FAIL midrst_async: got v=%b c=%0d b=%b want v=0 c=0 b=0", chg_valid, credit, busy); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    chg_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_vend();
    test_funds();
    test_overflow();
    test_refund();
    test_stall();
    test_soldout();
    test_restock_vend();
    test_simul();
    test_reset_mid_change();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
